// File: rtl/wb_stage_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg
//   Parametrised MEM->WB pipeline stage register. It latches PC, instruction,
//   destination and NSRC generic result channels together with a valid bit.
//   It produces the register-file write data through a registered one-hot
//   source select.
//
//   Update priority on each rising edge:
//     reset > req > flush > stall > load
//   All outputs are driven from registers only. No in_* signal reaches an
//   output combinationally.
//
// Parameters
//   DW        width of each result channel and of W_RegWD
//   NSRC      number of result channels
//   AW        register-file address width
//   RESET_PC  out_pc value after reset
//   EXC_PC    out_pc value after an exception request
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high reset
//   req        exception/interrupt request; bubble carrying EXC_PC
//   stall      hold all stage contents
//   flush      insert a bubble; the incoming PC is kept
//   in_valid   incoming instruction valid
//   in_pc      incoming PC
//   in_instr   incoming instruction word
//   in_src     packed result channels; channel k = in_src[k*DW +: DW]
//   in_sel     one-hot write-back source select
//   in_we      register write enable
//   in_waddr   destination register
//   out_valid  stage holds a valid instruction
//   out_pc     registered PC
//   out_instr  registered instruction
//   out_we     qualified write enable (valid, enabled, destination != 0)
//   out_waddr  registered destination
//   out_sel    registered select
//   W_RegWD    selected write-back data; 0 when the stage is invalid or the
//              select is not one-hot
//   out_retired (only with WB_RETIRE_CNT_EN) 32-bit count of instructions
//              that left the stage
//
// Optional feature macro: WB_RETIRE_CNT_EN
// -----------------------------------------------------------------------------
module wb_stage_reg #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NSRC     = 6,
  parameter int unsigned AW       = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_instr,
  input  logic [NSRC*DW-1:0] in_src,
  input  logic [NSRC-1:0]    in_sel,
  input  logic               in_we,
  input  logic [AW-1:0]      in_waddr,
  output logic               out_valid,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic               out_we,
  output logic [AW-1:0]      out_waddr,
  output logic [NSRC-1:0]    out_sel,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]        out_retired,
`endif
  output logic [DW-1:0]      W_RegWD
);

  logic               valid_q, valid_d;
  logic [31:0]        pc_q,    pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [NSRC*DW-1:0] src_q,   src_d;
  logic [NSRC-1:0]    sel_q,   sel_d;
  logic               we_q,    we_d;
  logic [AW-1:0]      waddr_q, waddr_d;

  // Next-state selection. Reset is applied in the sequential block. req and
  // flush both override stall, so a bubble can always be injected.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    src_d   = src_q;
    sel_d   = sel_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    if (req) begin
      valid_d = 1'b0;
      pc_d    = EXC_PC;
      instr_d = '0;
      src_d   = '0;
      sel_d   = '0;
      we_d    = 1'b0;
      waddr_d = '0;
    end else if (flush) begin
      valid_d = 1'b0;
      pc_d    = in_pc;
      instr_d = '0;
      src_d   = '0;
      sel_d   = '0;
      we_d    = 1'b0;
      waddr_d = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      pc_d    = in_pc;
      instr_d = in_instr;
      src_d   = in_src;
      sel_d   = in_sel;
      we_d    = in_we;
      waddr_d = in_waddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      src_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      src_q   <= src_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
    end
  end

  // Write-back mux. It is an AND-OR over the channels, qualified by a strict
  // one-hot test. A zero or multi-hot select yields 0 instead of an OR of
  // several channels.
  logic          sel_onehot;
  logic [DW-1:0] mux_or;

  always_comb begin
    sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
    mux_or     = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (sel_q[k]) begin
        mux_or = mux_or | src_q[k*DW +: DW];
      end
    end
  end

  assign W_RegWD   = (valid_q && sel_onehot) ? mux_or : '0;
  assign out_we    = valid_q & we_q & (waddr_q != '0);
  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_waddr = waddr_q;
  assign out_sel   = sel_q;

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires when it leaves the stage, which happens on any
  // unstalled edge. req and flush replace it but still count it.
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (valid_q && !stall) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign out_retired = retired_q;
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;
  localparam int unsigned DW   = 32;
  localparam int unsigned NSRC = 6;
  localparam int unsigned AW   = 5;
  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam logic [31:0] XPC  = 32'h0000_4180;

  logic               clk = 1'b0;
  logic               reset, req, stall, flush, in_valid, in_we;
  logic [31:0]        in_pc, in_instr;
  logic [DW-1:0]      ch [NSRC];
  logic [NSRC*DW-1:0] in_src;
  logic [NSRC-1:0]    in_sel;
  logic [AW-1:0]      in_waddr;
  logic               out_valid, out_we;
  logic [31:0]        out_pc, out_instr;
  logic [AW-1:0]      out_waddr;
  logic [NSRC-1:0]    out_sel;
  logic [DW-1:0]      W_RegWD;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]        out_retired;
`endif

  always #5 clk = ~clk;

  always_comb begin
    in_src = '0;
    for (int k = 0; k < NSRC; k++) in_src[k*DW +: DW] = ch[k];
  end

  wb_stage_reg #(.DW(DW), .NSRC(NSRC), .AW(AW), .RESET_PC(RPC), .EXC_PC(XPC)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_src(in_src),
    .in_sel(in_sel), .in_we(in_we), .in_waddr(in_waddr),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_we(out_we), .out_waddr(out_waddr), .out_sel(out_sel),
`ifdef WB_RETIRE_CNT_EN
    .out_retired(out_retired),
`endif
    .W_RegWD(W_RegWD));

  int tests = 0;
  int fails = 0;

  // Behavioural model of the stage contents.
  logic          m_valid, m_we;
  logic [31:0]   m_pc, m_instr, m_ret;
  logic [DW-1:0] m_src [NSRC];
  logic [NSRC-1:0] m_sel;
  logic [AW-1:0] m_waddr;

  function automatic logic [DW-1:0] exp_wd();
    if (!m_valid || $countones(m_sel) != 1) return '0;
    for (int k = 0; k < NSRC; k++) if (m_sel[k]) return m_src[k];
    return '0;
  endfunction

  function automatic logic exp_we();
    return m_valid && m_we && (m_waddr != 0);
  endfunction

  task automatic bubble(input logic [31:0] pc);
    m_valid = 0; m_pc = pc; m_instr = 0; m_sel = 0; m_we = 0; m_waddr = 0;
    for (int k = 0; k < NSRC; k++) m_src[k] = 0;
  endtask

  // Clock edge plus model update from the inputs present at that edge. The
  // outputs are then settled and can be sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      bubble(RPC);
      m_ret = 0;
    end else begin
      if (m_valid && !stall) m_ret = m_ret + 1;
      if (req) bubble(XPC);
      else if (flush) bubble(in_pc);
      else if (!stall) begin
        m_valid = in_valid; m_pc = in_pc; m_instr = in_instr; m_sel = in_sel;
        m_we = in_we; m_waddr = in_waddr;
        for (int k = 0; k < NSRC; k++) m_src[k] = ch[k];
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; req = 0; stall = 0; flush = 0; in_valid = 0; in_we = 0;
    in_pc = 0; in_instr = 0; in_sel = 0; in_waddr = 0;
    for (int k = 0; k < NSRC; k++) ch[k] = 0;
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom); in_we = 1'($urandom);
    in_pc = $urandom; in_instr = $urandom; in_waddr = AW'($urandom);
    case ($urandom_range(0, 3))
      0: in_sel = NSRC'($urandom);
      1: in_sel = '0;
      default: in_sel = NSRC'(1) << $urandom_range(0, NSRC - 1);
    endcase
    for (int k = 0; k < NSRC; k++) ch[k] = $urandom;
  endtask

  task automatic test_reset();
    rand_inputs(); reset = 1; stall = 1; req = 0; flush = 0; in_valid = 1;
    tick();
    reset = 0; stall = 0;
    tests++; if (out_pc !== 32'h0000_3000) begin fails++; $display("FAIL reset_pc got %h exp %h", out_pc, 32'h0000_3000); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", out_we); end
    tests++; if (W_RegWD !== '0) begin fails++; $display("FAIL reset_wd got %h exp 0", W_RegWD); end
    tests++; if (out_instr !== '0) begin fails++; $display("FAIL reset_instr got %h exp 0", out_instr); end
  endtask

  task automatic test_load_select();
    idle_inputs();
    in_valid = 1; in_pc = 32'h3004; in_instr = 32'h1234_5678; in_sel = 6'b000010;
    ch[0] = 32'h0BAD_0000; ch[1] = 32'hDEAD_BEEF; ch[2] = 32'hFFFF_FFFF;
    in_we = 1; in_waddr = 5'd8;
    tick();
    tests++; if (W_RegWD !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_wd got %h exp deadbeef", W_RegWD); end
    tests++; if (out_we !== 1'b1) begin fails++; $display("FAIL load_we got %b exp 1", out_we); end
    tests++; if (out_waddr !== 5'd8) begin fails++; $display("FAIL load_waddr got %0d exp 8", out_waddr); end
    tests++; if (out_pc !== 32'h3004) begin fails++; $display("FAIL load_pc got %h exp 3004", out_pc); end
    in_waddr = 5'd0;
    tick();
    tests++; if (out_we !== 1'b0) begin fails++; $display("FAIL load_r0_we got %b exp 0", out_we); end
    tests++; if (W_RegWD !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_r0_wd got %h exp deadbeef", W_RegWD); end
    // Invalid incoming instruction: a write-enable and select are present but ignored.
    in_valid = 0; in_waddr = 5'd3;
    tick();
    tests++; if (out_we !== 1'b0 || W_RegWD !== '0) begin fails++; $display("FAIL invalid_gate got we=%b wd=%h exp we=0 wd=0", out_we, W_RegWD); end
  endtask

  task automatic test_stall();
    idle_inputs();
    in_valid = 1; in_sel = 6'b000001; ch[0] = 32'h11; in_we = 1; in_waddr = 5'd4; in_pc = 32'h3020;
    tick();
    ch[0] = 32'h22; in_pc = 32'h3024; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (W_RegWD !== 32'h11 || out_pc !== 32'h3020) begin fails++; $display("FAIL stall_hold%0d got wd=%h pc=%h exp wd=11 pc=3020", i, W_RegWD, out_pc); end
    end
    stall = 0;
    tick();
    tests++; if (W_RegWD !== 32'h22) begin fails++; $display("FAIL stall_release got %h exp 22", W_RegWD); end
  endtask

  task automatic test_flush_req();
    idle_inputs();
    in_valid = 1; in_sel = 6'b000100; ch[2] = 32'hCAFE; in_pc = 32'h300C; in_instr = 32'hABCD;
    tick();
    flush = 1; in_pc = 32'h3010;
    tick();
    tests++; if (out_valid !== 1'b0 || out_pc !== 32'h3010 || W_RegWD !== '0) begin fails++; $display("FAIL flush got v=%b pc=%h wd=%h exp v=0 pc=3010 wd=0", out_valid, out_pc, W_RegWD); end
    flush = 0;
    tick();
    req = 1; flush = 1; stall = 1; in_pc = 32'h3014;
    tick();
    tests++; if (out_pc !== 32'h0000_4180 || out_instr !== '0) begin fails++; $display("FAIL req got pc=%h instr=%h exp pc=4180 instr=0", out_pc, out_instr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL req_valid got %b exp 0", out_valid); end
    req = 0; flush = 1; stall = 1; in_pc = 32'h3018;
    tick();
    tests++; if (out_pc !== 32'h3018 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_stall got pc=%h v=%b exp pc=3018 v=0", out_pc, out_valid); end
    flush = 0; stall = 0;
  endtask

  task automatic test_bad_sel();
    idle_inputs();
    in_valid = 1; for (int k = 0; k < NSRC; k++) ch[k] = 32'h100 + k;
    in_sel = 6'b000110;
    tick();
    tests++; if (W_RegWD !== '0 || out_valid !== 1'b1) begin fails++; $display("FAIL bad_sel_multi got wd=%h v=%b exp wd=0 v=1", W_RegWD, out_valid); end
    in_sel = 6'b000000;
    tick();
    tests++; if (W_RegWD !== '0 || out_valid !== 1'b1) begin fails++; $display("FAIL bad_sel_zero got wd=%h v=%b exp wd=0 v=1", W_RegWD, out_valid); end
    in_sel = 6'b100000;
    tick();
    tests++; if (W_RegWD !== 32'h105) begin fails++; $display("FAIL sel_top got %h exp 105", W_RegWD); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 39) == 0);
      req   = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      tick();
      tests++;
      if (out_valid !== m_valid || out_pc !== m_pc || out_instr !== m_instr ||
          out_sel !== m_sel || out_waddr !== m_waddr || out_we !== exp_we() ||
          W_RegWD !== exp_wd()) begin
        fails++;
        $display("FAIL random%0d got v=%b pc=%h ins=%h sel=%b wa=%0d we=%b wd=%h exp v=%b pc=%h ins=%h sel=%b wa=%0d we=%b wd=%h",
                 i, out_valid, out_pc, out_instr, out_sel, out_waddr, out_we, W_RegWD,
                 m_valid, m_pc, m_instr, m_sel, m_waddr, exp_we(), exp_wd());
      end
`ifdef WB_RETIRE_CNT_EN
      tests++; if (out_retired !== m_ret) begin fails++; $display("FAIL random_ret%0d got %0d exp %0d", i, out_retired, m_ret); end
`endif
    end
    idle_inputs();
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire();
    idle_inputs(); reset = 1; tick(); reset = 0;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin in_pc = 32'h3000 + 4 * i; tick(); end
    stall = 1; tick(); tick(); stall = 0;
    flush = 1; tick(); flush = 0;
    tests++; if (out_retired !== 32'd5) begin fails++; $display("FAIL retire_count got %0d exp 5", out_retired); end
    in_valid = 1; tick();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    tick();
    tests++; if (out_retired !== 32'd0) begin fails++; $display("FAIL retire_wrap got %h exp 0", out_retired); end
    m_ret = out_retired;
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    bubble(RPC); m_ret = 0;
    @(negedge clk);
    test_reset();
    test_load_select();
    test_stall();
    test_flush_req();
    test_bad_sel();
`ifdef WB_RETIRE_CNT_EN
    test_retire();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
